// File: rtl/frac_rate_ctrl.sv
// Fractional-rate selection controller: resynchronises detector levels, samples once per window, and debounces into frac_sel/rate_locked.
// Optional hunt mode (toggle frac_sel after repeated empty windows in SEARCH) is enabled by defining FRAC_SEL_HUNT_EN.
module frac_rate_ctrl #(
  parameter int unsigned pwin       = 148500,
  parameter int unsigned pconfirm   = 3,
  parameter int unsigned pmiss      = 2,
  parameter int unsigned ptimeout   = 8,
  parameter bit          pfrac_init = 1'b0
) (
  input  logic       ref_clk,
  input  logic       rstn,
  input  logic       ce,
  input  logic       det_frac_intn,
  input  logic       det_out_valid,
  output logic       frac_sel,
  output logic       rate_locked,
  output logic       rate_chg,
  output logic       win_tick,
  output logic [1:0] state
);

  localparam int unsigned WIN_W = 18;
  localparam int unsigned AGR_W = 4;
  localparam int unsigned MIS_W = 4;
  localparam int unsigned TO_W  = 8;

  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(pwin - 1);
  localparam logic [AGR_W-1:0] CONFIRM_N = AGR_W'(pconfirm);
  localparam logic [MIS_W-1:0] MISS_N    = MIS_W'(pmiss);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(ptimeout);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  logic [1:0]       r_frac_sync;
  logic [1:0]       r_valid_sync;
  logic [WIN_W-1:0] r_win_cnt;
  state_t           r_state;
  logic             r_cand;
  logic [AGR_W-1:0] r_agree;
  logic [MIS_W-1:0] r_miss;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_frac_sel;
  logic             r_rate_locked;
  logic             r_rate_chg;
  logic             r_win_tick;

  logic             w_s_frac;
  logic             w_s_valid;
  logic             w_tick;
  state_t           w_state_nxt;
  logic             w_cand_nxt;
  logic [AGR_W-1:0] w_agree_nxt;
  logic [MIS_W-1:0] w_miss_nxt;
  logic [TO_W-1:0]  w_to_nxt;
  logic             w_frac_nxt;
  logic             w_chg_nxt;

  // Two-flop synchronisers; free-running so the sampled level is always fresh
  always_ff @(posedge ref_clk or negedge rstn) begin
    if (!rstn) begin
      r_frac_sync  <= 2'b00;
      r_valid_sync <= 2'b00;
    end else begin
      r_frac_sync  <= {r_frac_sync[0], det_frac_intn};
      r_valid_sync <= {r_valid_sync[0], det_out_valid};
    end
  end

  assign w_s_frac  = r_frac_sync[1];
  assign w_s_valid = r_valid_sync[1];

  // Measurement window; the sample point is the last enabled cycle of each window
  assign w_tick = ce && (r_win_cnt == WIN_LAST);

  always_ff @(posedge ref_clk or negedge rstn) begin
    if (!rstn) begin
      r_win_cnt <= '0;
    end else if (ce) begin
      r_win_cnt <= w_tick ? '0 : r_win_cnt + WIN_W'(1);
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge ref_clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_SEARCH;
      r_cand        <= 1'b0;
      r_agree       <= '0;
      r_miss        <= '0;
      r_to_cnt      <= '0;
      r_frac_sel    <= pfrac_init;
      r_rate_locked <= 1'b0;
      r_rate_chg    <= 1'b0;
      r_win_tick    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cand        <= w_cand_nxt;
      r_agree       <= w_agree_nxt;
      r_miss        <= w_miss_nxt;
      r_to_cnt      <= w_to_nxt;
      r_frac_sel    <= w_frac_nxt;
      r_rate_locked <= (w_state_nxt == ST_LOCKED);
      r_rate_chg    <= w_chg_nxt;
      r_win_tick    <= w_tick;
    end
  end

  // Next-state logic; every decision is qualified by w_tick, which already includes ce
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_agree_nxt = r_agree;
    w_miss_nxt  = r_miss;
    w_to_nxt    = r_to_cnt;
    w_frac_nxt  = r_frac_sel;
    w_chg_nxt   = 1'b0;

    case (r_state)
      ST_SEARCH: begin
        if (w_tick) begin
          if (w_s_valid) begin
            w_cand_nxt  = w_s_frac;
            w_agree_nxt = AGR_W'(1);
            w_to_nxt    = '0;
            w_state_nxt = ST_CONFIRM;
          end else begin
`ifdef FRAC_SEL_HUNT_EN
            if ((r_to_cnt + TO_W'(1)) == TO_LIMIT) begin
              w_frac_nxt = ~r_frac_sel;
              w_chg_nxt  = 1'b1;
              w_to_nxt   = '0;
            end else begin
              w_to_nxt = r_to_cnt + TO_W'(1);
            end
`else
            w_to_nxt = (r_to_cnt >= TO_LIMIT) ? r_to_cnt : r_to_cnt + TO_W'(1);
`endif
          end
        end
      end

      ST_CONFIRM: begin
        if (w_tick) begin
          if (!w_s_valid) begin
            w_agree_nxt = '0;
            w_state_nxt = ST_SEARCH;
          end else if (w_s_frac != r_cand) begin
            w_cand_nxt  = w_s_frac;
            w_agree_nxt = AGR_W'(1);
          end else if ((r_agree + AGR_W'(1)) == CONFIRM_N) begin
            w_agree_nxt = '0;
            w_miss_nxt  = '0;
            w_frac_nxt  = r_cand;
            w_chg_nxt   = (r_cand != r_frac_sel);
            w_state_nxt = ST_LOCKED;
          end else begin
            w_agree_nxt = r_agree + AGR_W'(1);
          end
        end
      end

      ST_LOCKED: begin
        if (w_tick) begin
          if (w_s_valid && (w_s_frac == r_frac_sel)) begin
            w_miss_nxt = '0;
          end else if ((r_miss + MIS_W'(1)) == MISS_N) begin
            w_miss_nxt  = '0;
            w_to_nxt    = '0;
            w_state_nxt = ST_SEARCH;
          end else begin
            w_miss_nxt = r_miss + MIS_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

  assign frac_sel    = r_frac_sel;
  assign rate_locked = r_rate_locked;
  assign rate_chg    = r_rate_chg;
  assign win_tick    = r_win_tick;
  assign state       = r_state;

endmodule

// File: tb/tb_frac_rate_ctrl.sv
// Bench for frac_rate_ctrl: directed and random windows checked against a sample-history model.
module tb_frac_rate_ctrl;

  localparam int unsigned PWIN  = 16;
  localparam int unsigned PCONF = 3;
  localparam int unsigned PMISS = 2;
  localparam int unsigned PTO   = 8;
  localparam bit          PINIT = 1'b0;

  logic       ref_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ce = 1'b0;
  logic       det_frac_intn = 1'b0;
  logic       det_out_valid = 1'b0;
  logic       frac_sel;
  logic       rate_locked;
  logic       rate_chg;
  logic       win_tick;
  logic [1:0] state;

  frac_rate_ctrl #(
    .pwin(PWIN), .pconfirm(PCONF), .pmiss(PMISS), .ptimeout(PTO), .pfrac_init(PINIT)
  ) u_dut (
    .ref_clk(ref_clk), .rstn(rstn), .ce(ce),
    .det_frac_intn(det_frac_intn), .det_out_valid(det_out_valid),
    .frac_sel(frac_sel), .rate_locked(rate_locked), .rate_chg(rate_chg),
    .win_tick(win_tick), .state(state)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct packed { logic v; logic f; } samp_t;

  // Model: samples seen in the current episode (unlocked hunt or locked hold)
  samp_t hist[$];
  int    checks = 0;
  int    errors = 0;
  int    m_cnt;
  int    m_to;
  bit    m_locked;
  bit    m_sel;
  bit    exp_tick;
  bit    exp_chg;
  logic  cur_v;
  logic  cur_f;

  task automatic model_reset();
    m_cnt = 0; m_to = 0; m_locked = 1'b0; m_sel = PINIT;
    exp_tick = 1'b0; exp_chg = 1'b0;
    hist.delete();
  endtask

  function automatic logic [1:0] exp_state();
    if (m_locked) return 2'd2;
    if (hist.size() > 0 && hist[hist.size()-1].v) return 2'd1;
    return 2'd0;
  endfunction

  // Lock after PCONF trailing equal valid samples; unlock after PMISS trailing bad samples
  task automatic model_tick();
    samp_t s;
    int    run;
    int    bad;
    bit    was_search;
    s.v = cur_v; s.f = cur_f;
    if (!m_locked) begin
      was_search = (hist.size() == 0) || !hist[hist.size()-1].v;
      hist.push_back(s);
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i].v && hist[i].f == s.f) run++;
        else break;
      end
      if (was_search && !s.v) begin
        if (m_to < 255) m_to++;
`ifdef FRAC_SEL_HUNT_EN
        if (m_to == PTO) begin m_to = 0; m_sel = !m_sel; exp_chg = 1'b1; end
`endif
      end else if (was_search) begin
        m_to = 0;
      end
      if (run >= PCONF) begin
        exp_chg  = (s.f != m_sel);
        m_sel    = s.f;
        m_locked = 1'b1;
        hist.delete();
      end
    end else begin
      hist.push_back(s);
      bad = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (!hist[i].v || hist[i].f != m_sel) bad++;
        else break;
      end
      if (bad >= PMISS) begin
        m_locked = 1'b0;
        m_to = 0;
        hist.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("win_tick", {1'b0, win_tick}, {1'b0, exp_tick});
    chk("rate_chg", {1'b0, rate_chg}, {1'b0, exp_chg});
    chk("frac_sel", {1'b0, frac_sel}, {1'b0, m_sel});
    chk("rate_locked", {1'b0, rate_locked}, {1'b0, m_locked});
    chk("state", state, exp_state());
  endtask

  task automatic step(input logic ce_v);
    ce = ce_v;
    @(posedge ref_clk);
    #1;
    exp_tick = 1'b0;
    exp_chg  = 1'b0;
    if (rstn && ce_v) begin
      if (m_cnt == PWIN - 1) begin
        m_cnt = 0;
        exp_tick = 1'b1;
        model_tick();
      end else begin
        m_cnt++;
      end
    end
    check_all();
  endtask

  // Hold one detector value for a whole window; mode 0 ce=1, 1 alternating, 2 random
  task automatic window(input logic v, input logic f, input int mode);
    int   n;
    logic c;
    n = 0;
    det_out_valid = v; det_frac_intn = f; cur_v = v; cur_f = f;
    do begin
      case (mode)
        0:       c = 1'b1;
        1:       c = (n % 2 == 0);
        default: c = 1'($urandom % 2);
      endcase
      step(c);
      n++;
    end while (!exp_tick && n < 400);
    if (!exp_tick) begin
      checks++;
      errors++;
      $error("FAIL window_timeout observed no tick expected tick within 400 cycles");
    end
  endtask

  initial begin
    logic rv;
    logic rf;

    model_reset();
    cur_v = 1'b1; cur_f = 1'b1;
    det_out_valid = 1'b1; det_frac_intn = 1'b1;
    rstn = 1'b0;
    repeat (3) step(1'b1);
    rstn = 1'b1;

    // Constant frac from reset: lock on the third tick with one rate_chg
    repeat (3) window(1'b1, 1'b1, 0);
    chk("p1_locked", {1'b0, rate_locked}, 2'd1);
    chk("p1_frac", {1'b0, frac_sel}, 2'd1);

    // Reset mid-window while locked
    repeat (5) step(1'b1);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) step(1'b1);
    rstn = 1'b1;

    // Lock at int (no change pulse), then miss handling
    repeat (3) window(1'b1, 1'b0, 0);
    window(1'b0, 1'b0, 0);
    chk("p2_hold", {1'b0, rate_locked}, 2'd1);
    window(1'b1, 1'b0, 0);
    window(1'b0, 1'b0, 0);
    window(1'b0, 1'b0, 0);
    chk("p2_drop", state, 2'd0);

    // Candidate switch inside CONFIRM
    window(1'b1, 1'b0, 0);
    window(1'b1, 1'b0, 0);
    window(1'b1, 1'b1, 0);
    chk("p3_no_lock", state, 2'd1);
    window(1'b1, 1'b1, 0);
    window(1'b1, 1'b1, 0);
    chk("p3_lock_frac", {1'b0, frac_sel}, 2'd1);

    // Disagreeing samples drop lock, then a long invalid stretch
    window(1'b1, 1'b0, 0);
    window(1'b1, 1'b0, 0);
    repeat (10) window(1'b0, 1'b0, 0);

    // Half-rate clock enable during a confirm sequence
    repeat (3) window(1'b1, 1'b0, 1);
    chk("p5_lock", {1'b0, rate_locked}, 2'd1);

    // Random windows with random enable patterns
    rf = 1'b0;
    for (int k = 0; k < 60; k++) begin
      rv = (($urandom % 4) != 0);
      if (($urandom % 5) == 0) rf = ~rf;
      window(rv, rf, int'($urandom % 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
